// File: rtl/memory_access_stage_pkg.sv
// memory_access_stage_pkg: control-bit indices, size encodings and FSM states for the MEM stage.
package memory_access_stage_pkg;

    localparam int CU_MEM_READ      = 0;
    localparam int CU_MEM_WRITE     = 1;
    localparam int CU_SIZE          = 2;
    localparam int CU_LOAD_UNSIGNED = 4;
    localparam int CU_REG_WRITE     = 5;
    localparam int CU_MEM_TO_REG    = 6;
    localparam int CU_VALID         = 7;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    function automatic logic is_aligned(logic [1:0] size, logic [1:0] a);
        return size == SZ_B || (size == SZ_H && !a[0]) || (size == SZ_W && a == 2'b00);
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// memory_access_stage_if: data-memory req/ready bus between the MEM stage and memory.
interface memory_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ready, rdata);
    modport slave  (input req, we, addr, be, wdata, output ready, rdata);
endinterface

// File: rtl/memory_access_stage_load_store_align.sv
// memory_access_stage_load_store_align: byte-lane enables, store replication and load extension.
module memory_access_stage_load_store_align
    import memory_access_stage_pkg::*;
(
    input  logic [1:0]  a,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_ext
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = rdata[{a, 3'b000} +: 8];
        half_v     = a[1] ? rdata[31:16] : rdata[15:0];
        be         = size == SZ_B ? 4'b0001 << a :
                     size == SZ_H ? (a[1] ? 4'b1100 : 4'b0011) :
                     size == SZ_W ? 4'b1111 : 4'b0000;
        wdata_lane = size == SZ_B ? {4{wdata[7:0]}} :
                     size == SZ_H ? {2{wdata[15:0]}} : wdata;
        load_ext   = size == SZ_B ? {{24{!load_unsigned & byte_v[7]}}, byte_v} :
                     size == SZ_H ? {{16{!load_unsigned & half_v[15]}}, half_v} : rdata;
    end
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM pipeline stage issuing data-memory loads/stores over a req/ready bus,
// stalling while memory is busy and registering the MEM/WB bundle.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4:0]                    i_rd,
    input  logic [31:0]                   i_mem_write_data,
    input  logic [7:0]                    i_control_unit_signal,
    input  logic [31:0]                   i_alu_out,
    memory_access_stage_if.master         dmem,
    output logic                          stall,
    output logic                          misalign,
    output logic                          bus_error,
    output logic [4:0]                    o_rd,
    output logic [31:0]                   o_wb_data,
    output logic                          o_reg_write,
    output logic                          o_valid
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [CW-1:0] count;
    logic [7:0]  c_ctrl, ctrl;
    logic [4:0]  c_rd, rd;
    logic [31:0] c_alu, alu, c_data, data;
    logic        mem_op, ok, done, abort, mis;
    logic [3:0]  be_a;
    logic [31:0] wdata_a, load_ext;

    memory_access_stage_load_store_align u_align (
        .a             (alu[1:0]),
        .size          (ctrl[CU_SIZE +: 2]),
        .load_unsigned (ctrl[CU_LOAD_UNSIGNED]),
        .wdata         (data),
        .rdata         (dmem.rdata),
        .be            (be_a),
        .wdata_lane    (wdata_a),
        .load_ext      (load_ext)
    );

    // In WAIT the bus is sourced from the captured op so it stays stable while upstream is frozen.
    always_comb begin
        ctrl       = state == S_WAIT ? c_ctrl : i_control_unit_signal;
        rd         = state == S_WAIT ? c_rd   : i_rd;
        alu        = state == S_WAIT ? c_alu  : i_alu_out;
        data       = state == S_WAIT ? c_data : i_mem_write_data;
        mem_op     = ctrl[CU_VALID] & (ctrl[CU_MEM_READ] | ctrl[CU_MEM_WRITE]);
        ok         = is_aligned(ctrl[CU_SIZE +: 2], alu[1:0]);
        mis        = mem_op & !ok;
        dmem.req   = rst_n & mem_op & ok;
        dmem.we    = dmem.req & ctrl[CU_MEM_WRITE];
        dmem.addr  = {alu[31:2], 2'b00};
        dmem.be    = dmem.req ? be_a : 4'b0000;
        dmem.wdata = wdata_a;
        done       = dmem.req & dmem.ready;
        abort      = state == S_WAIT & !dmem.ready & count >= LAST;
        stall      = dmem.req & !dmem.ready & !abort;
        state_nx   = stall ? S_WAIT : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            c_ctrl      <= '0;
            c_rd        <= '0;
            c_alu       <= '0;
            c_data      <= '0;
            misalign    <= 1'b0;
            bus_error   <= 1'b0;
            o_rd        <= '0;
            o_wb_data   <= '0;
            o_reg_write <= 1'b0;
            o_valid     <= 1'b0;
        end else begin
            state       <= state_nx;
            count       <= stall ? count + 1'b1 : '0;
            if (state == S_IDLE) begin
                c_ctrl <= i_control_unit_signal;
                c_rd   <= i_rd;
                c_alu  <= i_alu_out;
                c_data <= i_mem_write_data;
            end
            misalign    <= mis;
            bus_error   <= abort;
            o_rd        <= rd;
            o_wb_data   <= done & ctrl[CU_MEM_TO_REG] ? load_ext : alu;
            o_reg_write <= !stall & !abort & !mis & ctrl[CU_VALID] & ctrl[CU_REG_WRITE];
            o_valid     <= !stall & ctrl[CU_VALID];
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed and randomized checks of the MEM stage against a behavioural model.
module tb_memory_access_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  i_rd = '0;
    logic [31:0] i_mem_write_data = '0;
    logic [7:0]  i_control_unit_signal = '0;
    logic [31:0] i_alu_out = '0;
    logic        stall, misalign, bus_error, o_reg_write, o_valid;
    logic [4:0]  o_rd;
    logic [31:0] o_wb_data;
    int vectors = 0;
    int miscompares = 0;

    memory_access_stage_if bus ();

    memory_access_stage #(.TIMEOUT(16)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_rd                  (i_rd),
        .i_mem_write_data      (i_mem_write_data),
        .i_control_unit_signal (i_control_unit_signal),
        .i_alu_out             (i_alu_out),
        .dmem                  (bus),
        .stall                 (stall),
        .misalign              (misalign),
        .bus_error             (bus_error),
        .o_rd                  (o_rd),
        .o_wb_data             (o_wb_data),
        .o_reg_write           (o_reg_write),
        .o_valid               (o_valid)
    );

    always #5 clk = ~clk;

    // ctrl bits: [7]valid [6]mem_to_reg [5]reg_write [4]unsigned [3:2]size [1]write [0]read
    function automatic logic [7:0] mk(bit v, bit rd, bit wr, logic [1:0] sz, bit uns, bit rw, bit m2r);
        return {v, m2r, rw, uns, sz, wr, rd};
    endfunction

    function automatic logic [3:0] ref_be(int sz, logic [31:0] a);
        int off = int'(a % 32'd4);
        return sz == 0 ? 4'(1 << off) : sz == 1 ? 4'(3 << off) : 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(int sz, logic [31:0] d);
        return sz == 0 ? (d & 32'hFF) * 32'h01010101 : sz == 1 ? (d & 32'hFFFF) * 32'h00010001 : d;
    endfunction

    function automatic logic [31:0] ref_load(int sz, bit uns, logic [31:0] a, logic [31:0] r);
        longint v;
        int off = int'(a % 32'd4) * 8;
        if (sz == 2) return r;
        v = longint'((r >> off) & (sz == 0 ? 32'hFF : 32'hFFFF));
        if (!uns && v >= (sz == 0 ? 128 : 32768)) v -= (sz == 0 ? 256 : 65536);
        return 32'(v);
    endfunction

    task automatic drive(logic [7:0] c, logic [4:0] r, logic [31:0] d, logic [31:0] a);
        i_control_unit_signal = c;
        i_rd = r;
        i_mem_write_data = d;
        i_alu_out = a;
    endtask

    task automatic test_reset();
        bus.ready = 1'b0;
        bus.rdata = '0;
        drive('0, '0, '0, '0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus.req, stall, o_valid, misalign, bus_error, o_reg_write} !== 6'b0 || o_wb_data !== 32'h0 || o_rd !== 5'h0) begin
            miscompares++;
            $display("FAIL reset req=%0b stall=%0b valid=%0b wb=%h want all 0", bus.req, stall, o_valid, o_wb_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        @(negedge clk);
        drive(mk(1, 0, 0, 2'b00, 0, 1, 0), 5'd7, 32'hDEAD, 32'h1234);
        #1;
        vectors++;
        if (bus.req !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_req req=%0b stall=%0b want 0 0", bus.req, stall);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (o_valid !== 1'b1 || o_wb_data !== 32'h1234 || o_rd !== 5'd7 || o_reg_write !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_wb valid=%0b wb=%h rd=%0d rw=%0b want 1 00001234 7 1", o_valid, o_wb_data, o_rd, o_reg_write);
        end
    endtask

    task automatic test_load_byte();
        logic [31:0] want [2] = '{32'hFFFFFF80, 32'h00000080};
        for (int u = 0; u < 2; u++) begin
            @(negedge clk);
            drive(mk(1, 1, 0, 2'b00, u[0], 1, 1), 5'd3, '0, 32'h103);
            bus.ready = 1'b1;
            bus.rdata = 32'h80123456;
            #1;
            vectors++;
            if (bus.req !== 1'b1 || bus.be !== 4'b1000 || bus.addr !== 32'h100 || bus.we !== 1'b0 || stall !== 1'b0) begin
                miscompares++;
                $display("FAIL lb_bus req=%0b be=%b addr=%h we=%0b stall=%0b want 1 1000 100 0 0", bus.req, bus.be, bus.addr, bus.we, stall);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (o_valid !== 1'b1 || o_wb_data !== want[u] || o_reg_write !== 1'b1) begin
                miscompares++;
                $display("FAIL lb_wb unsigned=%0d wb=%h valid=%0b want %h 1", u, o_wb_data, o_valid, want[u]);
            end
        end
        bus.ready = 1'b0;
    endtask

    task automatic test_store_half_wait();
        int stalls = 0;
        for (int cy = 0; cy < 4; cy++) begin
            @(negedge clk);
            if (cy == 0) drive(mk(1, 0, 1, 2'b01, 0, 0, 0), 5'd9, 32'h1234ABCD, 32'h102);
            else drive(i_control_unit_signal, 5'($urandom), $urandom, $urandom);
            bus.ready = cy == 3;
            #1;
            stalls += int'(stall);
            vectors++;
            if (bus.req !== 1'b1 || bus.be !== 4'b1100 || bus.wdata !== 32'hABCDABCD || bus.addr !== 32'h100 || bus.we !== 1'b1) begin
                miscompares++;
                $display("FAIL sh_bus cy=%0d req=%0b be=%b wdata=%h addr=%h want 1 1100 abcdabcd 100", cy, bus.req, bus.be, bus.wdata, bus.addr);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (o_valid !== (cy == 3)) begin
                miscompares++;
                $display("FAIL sh_valid cy=%0d valid=%0b want %0b", cy, o_valid, cy == 3);
            end
        end
        vectors++;
        if (stalls != 3 || o_reg_write !== 1'b0 || o_wb_data !== 32'h102 || o_rd !== 5'd9) begin
            miscompares++;
            $display("FAIL sh_done stalls=%0d rw=%0b wb=%h rd=%0d want 3 0 00000102 9", stalls, o_reg_write, o_wb_data, o_rd);
        end
        bus.ready = 1'b0;
    endtask

    task automatic test_misalign();
        @(negedge clk);
        drive(mk(1, 1, 0, 2'b10, 0, 1, 1), 5'd4, '0, 32'h101);
        #1;
        vectors++;
        if (bus.req !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_req req=%0b stall=%0b want 0 0", bus.req, stall);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (misalign !== 1'b1 || o_valid !== 1'b1 || o_reg_write !== 1'b0 || bus_error !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_pulse mis=%0b valid=%0b rw=%0b berr=%0b want 1 1 0 0", misalign, o_valid, o_reg_write, bus_error);
        end
        @(negedge clk);
        drive(mk(1, 0, 0, 2'b00, 0, 1, 0), 5'd4, '0, 32'h55);
        @(posedge clk);
        #1;
        vectors++;
        if (misalign !== 1'b0 || o_reg_write !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_clear mis=%0b rw=%0b want 0 1", misalign, o_reg_write);
        end
    endtask

    task automatic test_timeout();
        int stalls = 0;
        bit ended = 0;
        @(negedge clk);
        drive(mk(1, 1, 0, 2'b10, 0, 1, 1), 5'd6, '0, 32'h200);
        bus.ready = 1'b0;
        for (int cy = 0; cy < 40 && !ended; cy++) begin
            #1;
            if (stall) stalls++;
            else ended = 1;
            @(posedge clk);
            #1;
            if (!ended) @(negedge clk);
        end
        vectors++;
        if (!ended || stalls != 15 || bus_error !== 1'b1 || o_valid !== 1'b1 || o_reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout ended=%0b stalls=%0d berr=%0b valid=%0b rw=%0b want 1 15 1 1 0", ended, stalls, bus_error, o_valid, o_reg_write);
        end
        @(negedge clk);
        drive(mk(1, 0, 0, 2'b00, 0, 1, 0), 5'd6, '0, 32'h77);
        #1;
        vectors++;
        if (bus.req !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_idle req=%0b stall=%0b want 0 0", bus.req, stall);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus_error !== 1'b0 || o_wb_data !== 32'h77) begin
            miscompares++;
            $display("FAIL timeout_after berr=%0b wb=%h want 0 00000077", bus_error, o_wb_data);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        drive(mk(1, 1, 0, 2'b10, 0, 1, 1), 5'd8, '0, 32'h300);
        bus.ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.req !== 1'b0 || stall !== 1'b0 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wait req=%0b stall=%0b valid=%0b want 0 0 0", bus.req, stall, o_valid);
        end
        @(negedge clk);
        drive(mk(1, 1, 0, 2'b00, 0, 1, 1), 5'd8, '0, 32'h302);
        rst_n = 1'b1;
        bus.ready = 1'b1;
        bus.rdata = 32'h00FE0000;
        #1;
        vectors++;
        if (bus.req !== 1'b1 || bus.be !== 4'b0100 || bus.addr !== 32'h300) begin
            miscompares++;
            $display("FAIL rst_next_bus req=%0b be=%b addr=%h want 1 0100 300", bus.req, bus.be, bus.addr);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (o_valid !== 1'b1 || o_wb_data !== 32'hFFFFFFFE) begin
            miscompares++;
            $display("FAIL rst_next_wb valid=%0b wb=%h want 1 fffffffe", o_valid, o_wb_data);
        end
        bus.ready = 1'b0;
    endtask

    task automatic test_random();
        int k, sz, lat;
        bit uns, v, mem;
        logic [31:0] a, d, r, exp_wb;
        logic [7:0] c;
        logic [4:0] rdst;
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 3);
            a = $urandom;
            d = $urandom;
            r = $urandom;
            rdst = 5'($urandom_range(0, 31));
            sz = $urandom_range(0, 2);
            uns = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            lat = $urandom_range(0, 3);
            if (k == 1 || k == 2) a = a - a % (32'd1 << sz);
            if (k == 3) begin
                sz = $urandom_range(1, 3);
                if (sz == 1) a[0] = 1'b1;
                if (sz == 2) a[1:0] = 2'($urandom_range(1, 3));
            end
            c = k == 0 ? mk(v, 0, 0, 2'(sz), uns, 1, 0) :
                k == 2 ? mk(1, 0, 1, 2'(sz), uns, 0, 0) : mk(1, 1, 0, 2'(sz), uns, 1, 1);
            mem = k == 1 || k == 2;
            if (!mem) lat = 0;
            exp_wb = k == 1 ? ref_load(sz, uns, a, r) : a;
            for (int cy = 0; cy <= lat; cy++) begin
                @(negedge clk);
                if (cy == 0) drive(c, rdst, d, a);
                else drive(c, 5'($urandom), $urandom, $urandom);
                bus.ready = mem && cy == lat;
                bus.rdata = cy == lat ? r : $urandom;
                #1;
                vectors++;
                if (bus.req !== mem || stall !== (mem && cy < lat)) begin
                    miscompares++;
                    $display("FAIL rnd_hs n=%0d k=%0d req=%0b stall=%0b want %0b %0b", n, k, bus.req, stall, mem, mem && cy < lat);
                end
                if (mem) begin
                    vectors++;
                    if (bus.addr !== (a & ~32'd3) || bus.be !== ref_be(sz, a) || bus.we !== (k == 2) ||
                        (k == 2 && bus.wdata !== ref_wdata(sz, d))) begin
                        miscompares++;
                        $display("FAIL rnd_bus n=%0d addr=%h be=%b we=%0b wdata=%h want %h %b %0b %h", n, bus.addr, bus.be, bus.we,
                                 bus.wdata, a & ~32'd3, ref_be(sz, a), k == 2, ref_wdata(sz, d));
                    end
                end
                @(posedge clk);
                #1;
                vectors++;
                if (cy < lat) begin
                    if (o_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rnd_bubble n=%0d valid=%0b want 0", n, o_valid);
                    end
                end else if (o_valid !== (k == 0 ? v : 1'b1) || o_reg_write !== ((k == 0 && v) || k == 1) ||
                             o_wb_data !== exp_wb || o_rd !== rdst || misalign !== (k == 3) || bus_error !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_wb n=%0d k=%0d valid=%0b rw=%0b wb=%h rd=%0d mis=%0b want wb=%h rd=%0d", n, k, o_valid,
                             o_reg_write, o_wb_data, o_rd, misalign, exp_wb, rdst);
                end
            end
        end
        bus.ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half_wait();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
